avalon_sprite_flush_master: RTL

//  Avalon-MM master that drives the game-control register-file slave from the game-logic side.

---
 rtl/avalon_sprite_flush_master_if.sv | 22 ++
 rtl/avalon_sprite_flush_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_sprite_flush_master_if.sv
// Avalon-MM bus between the sprite flush master and the game-control register-file slave.
// Zero-latency reads: READDATA is valid in the cycle the read is accepted.
interface avalon_sprite_flush_master_if;
  logic [4:0]  AVM_ADDR;
  logic        AVM_READ;
  logic        AVM_WRITE;
  logic        AVM_CS;
  logic [7:0]  AVM_BYTE_EN;
  logic [63:0] AVM_WRITEDATA;
  logic [63:0] AVM_READDATA;
  logic        AVM_WAITREQUEST;

  modport master (
    output AVM_ADDR, AVM_READ, AVM_WRITE, AVM_CS, AVM_BYTE_EN, AVM_WRITEDATA,
    input  AVM_READDATA, AVM_WAITREQUEST
  );

  modport slave (
    input  AVM_ADDR, AVM_READ, AVM_WRITE, AVM_CS, AVM_BYTE_EN, AVM_WRITEDATA,
    output AVM_READDATA, AVM_WAITREQUEST
  );
endinterface

// File: rtl/avalon_sprite_flush_master.sv
// Flushes a local shadow table of sprite descriptors to the register-file slave:
// status read, then every dirty sprite entry, then the global word.
module avalon_sprite_flush_master #(
  parameter int NUM_SPRITES = 15,
  parameter int STATUS_ADDR = 30,
  parameter int GLOBAL_ADDR = 31
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  input  logic        TBL_WE,
  input  logic [3:0]  TBL_IDX,
  input  logic [63:0] TBL_WDATA,
  output logic [63:0] STATUS,
  output logic        STATUS_VALID,
  avalon_sprite_flush_master_if.master avm
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_SPRITES - 1);
  localparam logic [3:0] GLOB_IDX = 4'(NUM_SPRITES);
  localparam logic [4:0] STAT_A   = 5'(STATUS_ADDR);
  localparam logic [4:0] GLOB_A   = 5'(GLOBAL_ADDR);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_STAT = 3'd1,
    S_SCAN    = 3'd2,
    S_WRITE   = 3'd3,
    S_WR_GLOB = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic        redo_r, redo_s;
  logic        busy_r, done_r, done_s;
  logic [63:0] status_r, status_s;
  logic        status_valid_r, status_valid_s;
  logic [4:0]  addr_r, addr_s;
  logic        read_r, read_s, write_r, write_s;
  logic        cs_r;
  logic [7:0]  byte_en_r;
  logic [63:0] wdata_r, wdata_s;
  logic [63:0] shadow_r [0:15];
  logic [15:0] dirty_r, dirty_s;
  logic        clr_dirty_s;
  logic        accept_s, hit_cur_s, tbl_ok_s;

  assign accept_s  = !avm.AVM_WAITREQUEST;
  assign tbl_ok_s  = ({1'b0, TBL_IDX} <= {1'b0, GLOB_IDX});
  assign hit_cur_s = TBL_WE && (TBL_IDX == idx_r);

  // redo_r remembers a table write to the entry in flight after its data was latched,
  // so acceptance of the stale copy does not clear the dirty bit.
  // Next-state and next-output logic for the flush sequencer.
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    redo_s         = redo_r | hit_cur_s;
    done_s         = 1'b0;
    status_s       = status_r;
    status_valid_s = 1'b0;
    addr_s         = addr_r;
    read_s         = read_r;
    write_s        = write_r;
    wdata_s        = wdata_r;
    clr_dirty_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          state_s = S_RD_STAT;
          read_s  = 1'b1;
          addr_s  = STAT_A;
        end else begin
          read_s  = 1'b0;
          write_s = 1'b0;
        end
      end
      S_RD_STAT: begin
        if (accept_s) begin
          status_s       = avm.AVM_READDATA;
          status_valid_s = 1'b1;
          read_s         = 1'b0;
          addr_s         = 5'd0;
          idx_s          = 4'd0;
          state_s        = S_SCAN;
        end else begin
          state_s = S_RD_STAT;
        end
      end
      S_SCAN: begin
        if (dirty_r[idx_r] && (idx_r <= LAST_IDX)) begin
          write_s = 1'b1;
          addr_s  = {idx_r, 1'b1};
          wdata_s = shadow_r[idx_r];
          redo_s  = hit_cur_s;
          state_s = S_WRITE;
        end else if (idx_r >= LAST_IDX) begin
          write_s = 1'b1;
          addr_s  = GLOB_A;
          wdata_s = shadow_r[GLOB_IDX];
          idx_s   = GLOB_IDX;
          redo_s  = TBL_WE && (TBL_IDX == GLOB_IDX);
          state_s = S_WR_GLOB;
        end else begin
          idx_s = idx_r + 4'd1;
        end
      end
      S_WRITE: begin
        if (accept_s) begin
          clr_dirty_s = !redo_r;
          if (idx_r == LAST_IDX) begin
            addr_s  = GLOB_A;
            wdata_s = shadow_r[GLOB_IDX];
            idx_s   = GLOB_IDX;
            redo_s  = TBL_WE && (TBL_IDX == GLOB_IDX);
            state_s = S_WR_GLOB;
          end else begin
            write_s = 1'b0;
            addr_s  = 5'd0;
            idx_s   = idx_r + 4'd1;
            state_s = S_SCAN;
          end
        end else begin
          state_s = S_WRITE;
        end
      end
      S_WR_GLOB: begin
        if (accept_s) begin
          clr_dirty_s = !redo_r;
          write_s     = 1'b0;
          addr_s      = 5'd0;
          done_s      = 1'b1;
          state_s     = S_IDLE;
        end else begin
          state_s = S_WR_GLOB;
        end
      end
      default: begin
        state_s = S_IDLE;
        read_s  = 1'b0;
        write_s = 1'b0;
        addr_s  = 5'd0;
      end
    endcase
    // A table write beats a same-cycle clear so fresh data always goes out next flush.
    for (int j = 0; j < 16; j++) begin
      dirty_s[j] = (TBL_WE && tbl_ok_s && (TBL_IDX == 4'(j))) ? 1'b1 :
                   ((clr_dirty_s && (idx_r == 4'(j))) ? 1'b0 : dirty_r[j]);
    end
  end

  // Sequencer state and registered bus/status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r        <= S_IDLE;
      idx_r          <= 4'd0;
      redo_r         <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      status_r       <= 64'd0;
      status_valid_r <= 1'b0;
      addr_r         <= 5'd0;
      read_r         <= 1'b0;
      write_r        <= 1'b0;
      cs_r           <= 1'b0;
      byte_en_r      <= 8'h00;
      wdata_r        <= 64'd0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      redo_r         <= redo_s;
      busy_r         <= (state_s != S_IDLE);
      done_r         <= done_s;
      status_r       <= status_s;
      status_valid_r <= status_valid_s;
      addr_r         <= addr_s;
      read_r         <= read_s;
      write_r        <= write_s;
      cs_r           <= read_s | write_s;
      byte_en_r      <= (read_s | write_s) ? 8'hFF : 8'h00;
      wdata_r        <= wdata_s;
    end
  end

  // Shadow table and dirty bits; reset marks everything dirty so the first flush is complete.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int j = 0; j < 16; j++) begin
        shadow_r[j] <= 64'd0;
      end
      dirty_r <= 16'hFFFF;
    end else begin
      if (TBL_WE && tbl_ok_s) begin
        shadow_r[TBL_IDX] <= TBL_WDATA;
      end
      dirty_r <= dirty_s;
    end
  end

  assign BUSY              = busy_r;
  assign DONE              = done_r;
  assign STATUS            = status_r;
  assign STATUS_VALID      = status_valid_r;
  assign avm.AVM_ADDR      = addr_r;
  assign avm.AVM_READ      = read_r;
  assign avm.AVM_WRITE     = write_r;
  assign avm.AVM_CS        = cs_r;
  assign avm.AVM_BYTE_EN   = byte_en_r;
  assign avm.AVM_WRITEDATA = wdata_r;

endmodule
